// File: rtl/miniled_bank_sched_pkg.sv
// ============================================================================
// miniled_bank_sched_pkg
// Shared types and constants for the mini-LED bank scheduler.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package miniled_bank_sched_pkg;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } wr_state_e;

  localparam int         SCAN_LINES = 4;
  localparam logic [3:0] SCAN_RST   = 4'b0001;
  localparam int         LATCH_W    = 7;

endpackage

`default_nettype wire

// File: rtl/miniled_scan_cnt.sv
// ============================================================================
// miniled_scan_cnt
// Scan-line / latch-group position counter with end-of-frame pulse.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module miniled_scan_cnt
  import miniled_bank_sched_pkg::*;
#(
  parameter int LATCH_N = 64,
  parameter int SCAN_N  = SCAN_LINES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               latch,
  output logic [SCAN_N-1:0]  scan,
  output logic [LATCH_W-1:0] latch_cnt,
  output logic               frame_end
);

  localparam logic [LATCH_W-1:0] LAST_LATCH = LATCH_W'(LATCH_N - 1);
  localparam logic [SCAN_N-1:0]  SCAN_INIT  = SCAN_N'(SCAN_RST);

  logic w_line_done;

  assign w_line_done = (latch_cnt == LAST_LATCH);

  // A frame start resynchronises position and wins over a coincident latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan      <= SCAN_INIT;
      latch_cnt <= '0;
      frame_end <= 1'b0;
    end else if (frame_start) begin
      scan      <= SCAN_INIT;
      latch_cnt <= '0;
      frame_end <= 1'b0;
    end else if (latch) begin
      if (w_line_done) begin
        latch_cnt <= '0;
        scan      <= {scan[SCAN_N-2:0], scan[SCAN_N-1]};
        frame_end <= scan[SCAN_N-1];
      end else begin
        latch_cnt <= latch_cnt + LATCH_W'(1);
        frame_end <= 1'b0;
      end
    end else begin
      frame_end <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/miniled_bank_sched.sv
// ============================================================================
// miniled_bank_sched
// Double-buffered SRAM bank scheduler with writer FSM and scan sequencing.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module miniled_bank_sched
  import miniled_bank_sched_pkg::*;
#(
  parameter int LATCH_N = 64,
  parameter int SCAN_N  = SCAN_LINES
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic               I_wr_done,
  input  logic               I_rd_frame_start,
  input  logic               I_rd_latch,
  output logic               O_wr_bank,
  output logic               O_rd_bank,
  output logic               O_wr_en,
  output logic               O_swap,
  output logic               O_repeat,
  output logic               O_ovf,
  output logic [SCAN_N-1:0]  O_scan,
  output logic [LATCH_W-1:0] O_latch_cnt,
  output logic               O_frame_end
);

  wr_state_e r_state;
  wr_state_e w_state_nxt;
  logic      w_wr_bank_nxt;
  logic      w_wr_en_nxt;
  logic      w_swap_nxt;
  logic      w_repeat_nxt;
  logic      w_ovf_nxt;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_state   <= ST_FILL;
      O_wr_bank <= 1'b0;
      O_rd_bank <= 1'b1;
      O_wr_en   <= 1'b1;
      O_swap    <= 1'b0;
      O_repeat  <= 1'b0;
      O_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      O_wr_bank <= w_wr_bank_nxt;
      O_rd_bank <= ~w_wr_bank_nxt;
      O_wr_en   <= w_wr_en_nxt;
      O_swap    <= w_swap_nxt;
      O_repeat  <= w_repeat_nxt;
      O_ovf     <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: if (I_wr_done)        w_state_nxt = ST_FULL;
      ST_FULL: if (I_rd_frame_start) w_state_nxt = ST_FILL;
      default:                       w_state_nxt = ST_FILL;
    endcase
  end

  // A done arriving together with a frame start while filling defers the swap
  // to the following frame start; the current frame repeats the old bank.
  always_comb begin
    w_swap_nxt    = (r_state == ST_FULL) && I_rd_frame_start;
    w_repeat_nxt  = (r_state == ST_FILL) && I_rd_frame_start;
    w_wr_bank_nxt = O_wr_bank ^ w_swap_nxt;
    w_wr_en_nxt   = (w_state_nxt == ST_FILL);
    w_ovf_nxt     = O_ovf | ((r_state == ST_FULL) && I_wr_done);
  end

  miniled_scan_cnt #(
    .LATCH_N (LATCH_N),
    .SCAN_N  (SCAN_N)
  ) u_scan_cnt (
    .clk         (I_clk),
    .rst         (I_rst),
    .frame_start (I_rd_frame_start),
    .latch       (I_rd_latch),
    .scan        (O_scan),
    .latch_cnt   (O_latch_cnt),
    .frame_end   (O_frame_end)
  );

endmodule

`default_nettype wire

// File: tb/tb_miniled_bank_sched.sv
// ============================================================================
// tb_miniled_bank_sched
// Directed self-checking bench for the mini-LED bank scheduler.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_miniled_bank_sched;

  logic       clk;
  logic       rst;
  logic       wr_done;
  logic       rd_frame_start;
  logic       rd_latch;
  logic       wr_bank;
  logic       rd_bank;
  logic       wr_en;
  logic       swap;
  logic       rpt;
  logic       ovf;
  logic [3:0] scan;
  logic [6:0] latch_cnt;
  logic       frame_end;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_count;

  miniled_bank_sched #(
    .LATCH_N (64),
    .SCAN_N  (4)
  ) dut (
    .I_clk            (clk),
    .I_rst            (rst),
    .I_wr_done        (wr_done),
    .I_rd_frame_start (rd_frame_start),
    .I_rd_latch       (rd_latch),
    .O_wr_bank        (wr_bank),
    .O_rd_bank        (rd_bank),
    .O_wr_en          (wr_en),
    .O_swap           (swap),
    .O_repeat         (rpt),
    .O_ovf            (ovf),
    .O_scan           (scan),
    .O_latch_cnt      (latch_cnt),
    .O_frame_end      (frame_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs from a negedge; returns at the next negedge,
  // where the registered response to those inputs is visible.
  task automatic step(input logic wd, input logic fs, input logic lt);
    wr_done        = wd;
    rd_frame_start = fs;
    rd_latch       = lt;
    @(negedge clk);
    wr_done        = 1'b0;
    rd_frame_start = 1'b0;
    rd_latch       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".wr_bank"},   wr_bank,   1'b0);
    check({tag, ".rd_bank"},   rd_bank,   1'b1);
    check({tag, ".wr_en"},     wr_en,     1'b1);
    check({tag, ".swap"},      swap,      1'b0);
    check({tag, ".repeat"},    rpt,       1'b0);
    check({tag, ".ovf"},       ovf,       1'b0);
    check({tag, ".scan"},      scan,      4'b0001);
    check({tag, ".latch_cnt"}, latch_cnt, 7'd0);
    check({tag, ".frame_end"}, frame_end, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    wr_done        = 1'b0;
    rd_frame_start = 1'b0;
    rd_latch       = 1'b0;

    // Reset state held while rst is high, including over clock edges.
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;

    // Done at cycle 5, frame start at cycle 10 -> swap.
    idle(4);
    step(1'b1, 1'b0, 1'b0);
    check("done.wr_en", wr_en, 1'b0);
    check("done.swap",  swap,  1'b0);
    idle(4);
    step(1'b0, 1'b1, 1'b0);
    check("swap.pulse",   swap,    1'b1);
    check("swap.wr_bank", wr_bank, 1'b1);
    check("swap.rd_bank", rd_bank, 1'b0);
    check("swap.wr_en",   wr_en,   1'b1);
    check("swap.repeat",  rpt,     1'b0);
    idle(1);
    check("swap.oneshot", swap, 1'b0);

    // Frame start with no new data -> repeat, banks unchanged.
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    check("rep.pulse",   rpt,     1'b1);
    check("rep.swap",    swap,    1'b0);
    check("rep.wr_bank", wr_bank, 1'b0);
    check("rep.rd_bank", rd_bank, 1'b1);
    idle(1);
    check("rep.oneshot", rpt, 1'b0);

    // Simultaneous done and frame start from FILL.
    step(1'b1, 1'b1, 1'b0);
    check("sim.repeat", rpt,     1'b1);
    check("sim.wr_en",  wr_en,   1'b0);
    check("sim.swap",   swap,    1'b0);
    check("sim.bank",   wr_bank, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("sim2.swap",    swap,    1'b1);
    check("sim2.wr_bank", wr_bank, 1'b1);
    check("sim2.wr_en",   wr_en,   1'b1);
    check("sim2.ovf",     ovf,     1'b0);

    // Full frame of 256 latch pulses.
    step(1'b0, 1'b1, 1'b0);
    fe_count = 0;
    for (int i = 1; i <= 256; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (frame_end) fe_count++;
      if (i == 37)  check("scan.cnt37",   latch_cnt, 7'd37);
      if (i == 63)  check("scan.cnt63",   latch_cnt, 7'd63);
      if (i == 64)  check("scan.l1",      scan,      4'b0010);
      if (i == 64)  check("scan.wrap64",  latch_cnt, 7'd0);
      if (i == 128) check("scan.l2",      scan,      4'b0100);
      if (i == 192) check("scan.l3",      scan,      4'b1000);
      if (i == 255) check("scan.fe255",   frame_end, 1'b0);
      if (i == 256) check("scan.fe256",   frame_end, 1'b1);
      if (i == 256) check("scan.l0",      scan,      4'b0001);
      if (i == 256) check("scan.cnt_end", latch_cnt, 7'd0);
    end
    check("scan.fe_count", fe_count, 1);
    idle(1);
    check("scan.fe_oneshot", frame_end, 1'b0);

    // Frame start overrides a coincident latch, mid-line.
    idle(0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
    check("ovr.pre", latch_cnt, 7'd10);
    step(1'b0, 1'b1, 1'b1);
    check("ovr.cnt",  latch_cnt, 7'd0);
    check("ovr.scan", scan,      4'b0001);

    // Overflow is sticky across swaps until reset.
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    check("ovf.first", ovf, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("ovf.set",   ovf,   1'b1);
    check("ovf.wr_en", wr_en, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("ovf.swap",    swap, 1'b1);
    check("ovf.sticky1", ovf,  1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("ovf.swap2",   wr_bank, 1'b0);
    check("ovf.sticky2", ovf,     1'b1);
    do_reset();
    check("ovf.cleared", ovf, 1'b0);

    // Asynchronous reset mid-line while FULL.
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 37; i++) step(1'b0, 1'b0, 1'b1);
    check("arst.pre_cnt",   latch_cnt, 7'd37);
    check("arst.pre_wr_en", wr_en,     1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("arst");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    check("arst.after_cnt", latch_cnt, 7'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/miniled_bank_sched.md
MINILED_BANK_SCHED -- requirements
Module: miniled_bank_sched

Interface
REQ-001 Parameter LATCH_N, default 64, latch groups per scan line (2..127).
REQ-002 Parameter SCAN_N, default 4, scan lines per frame (fixed 4; one-hot scan output).
REQ-003 I_clk  input  1  system clock (25 MHz domain); one clock for the whole block.
REQ-004 I_rst  input  1  reset, asynchronous, active-high.
REQ-005 I_wr_done  input  1  single-cycle pulse, writer finished filling O_wr_bank.
REQ-006 I_rd_frame_start  input  1  single-cycle pulse, reader at frame boundary.
REQ-007 I_rd_latch  input  1  single-cycle pulse, reader finished one latch group.
REQ-008 O_wr_bank  output  1  SRAM bank the writer targets.
REQ-009 O_rd_bank  output  1  SRAM bank the reader consumes; always the inverse of O_wr_bank.
REQ-010 O_wr_en  output  1  writer permitted to write O_wr_bank.
REQ-011 O_swap  output  1  single-cycle pulse, banks exchanged.
REQ-012 O_repeat  output  1  single-cycle pulse, frame started with no new data; previous bank reused.
REQ-013 O_ovf  output  1  sticky, I_wr_done received while O_wr_en=0.
REQ-014 O_scan  output  4  one-hot scan-line select.
REQ-015 O_latch_cnt  output  7  latch index within current scan line.
REQ-016 O_frame_end  output  1  single-cycle pulse, last latch of last scan line done.

Function
REQ-017 All outputs are registered; every response appears exactly one I_clk cycle after the triggering input pulse.
REQ-018 The writer FSM has two states: FILL (O_wr_en=1) and FULL (O_wr_en=0).
REQ-019 In FILL, an I_wr_done pulse moves the FSM to FULL.
REQ-020 In FULL, an I_rd_frame_start pulse toggles both banks, pulses O_swap and returns the FSM to FILL.
REQ-021 In FILL, an I_rd_frame_start pulse keeps both banks unchanged and pulses O_repeat.
REQ-022 Simultaneous I_wr_done and I_rd_frame_start in FILL: FSM goes to FULL, no swap, O_repeat pulses; the swap happens at the next frame start.
REQ-023 I_wr_done in FULL: state is unchanged and O_ovf sets; O_ovf clears only on reset.
REQ-024 I_rd_frame_start forces O_scan=4'b0001 and O_latch_cnt=0 and overrides any I_rd_latch in the same cycle.
REQ-025 I_rd_latch without I_rd_frame_start increments O_latch_cnt.
REQ-026 At O_latch_cnt=LATCH_N-1, an I_rd_latch wraps O_latch_cnt to 0 and rotates O_scan left by one.
REQ-027 At O_scan=4'b1000 with O_latch_cnt=LATCH_N-1, an I_rd_latch wraps O_scan to 4'b0001 and pulses O_frame_end.
REQ-028 O_latch_cnt never reaches LATCH_N; O_scan is always exactly one-hot.
REQ-029 Banks change only on a frame start; the writer and reader never target the same bank.

Reset
REQ-030 While I_rst=1: O_wr_bank=0, O_rd_bank=1, O_wr_en=1, FSM=FILL, O_swap=0, O_repeat=0, O_ovf=0, O_scan=4'b0001, O_latch_cnt=0, O_frame_end=0.
REQ-031 Reset asserted mid-frame or mid-fill returns every output to its reset value asynchronously; no swap pulse is emitted.
REQ-032 After release, the first I_clk edge with I_rst=0 samples inputs normally.

Structure
REQ-033 A shared package holds the writer FSM state enum (FILL, FULL), the SCAN_N constant and the reset value 4'b0001.
REQ-034 The scan/latch counter is a sub-module named miniled_scan_cnt; the bank FSM, ovf flag and swap logic stay in the top.

Verification
REQ-035 Reset, then I_wr_done at cycle 5, then I_rd_frame_start at cycle 10 -> O_swap=1 at cycle 11, O_wr_bank=1, O_rd_bank=0, O_wr_en=1.
REQ-036 I_rd_frame_start with no prior I_wr_done -> O_repeat=1 one cycle later, banks unchanged at 0/1.
REQ-037 I_wr_done and I_rd_frame_start in the same cycle from FILL -> O_repeat=1 and O_wr_en=0; the next I_rd_frame_start yields O_swap=1.
REQ-038 LATCH_N=64, 256 I_rd_latch pulses after a frame start -> O_scan steps 0001, 0010, 0100, 1000 every 64 pulses; O_frame_end pulses once, after pulse 256; O_latch_cnt ends at 0.
REQ-039 Two I_wr_done pulses without a frame start -> O_ovf=1 and stays 1 through subsequent swaps until I_rst.
REQ-040 I_rst asserted at O_latch_cnt=37 in FULL state -> all outputs immediately take their REQ-030 values.
